vga_request_gen: RTL and testbench
==================================

VGA_REQUEST_GEN -- requirements
Module: vga_request_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP, default 16, horizontal front porch, clocks.
REQ-003 Parameter H_SYNC, default 96, horizontal sync width, clocks.
REQ-004 Parameter H_BP, default 48, horizontal back porch, clocks.
REQ-005 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 Parameter V_FP, V_SYNC, V_BP, defaults 10, 2, 33, vertical porches and sync, in lines.
REQ-007 iVgaClk  in  1  pixel clock; the only clock.
REQ-008 reset_n  in  1  reset, synchronous, active-low.
REQ-009 iFreezeReq  in  1  level; request to stop pixel-RAM writes.
REQ-010 oVgaHRequest  out  1  high while the column is in the active area.
REQ-011 oVgaVRequest  out  1  high while the row is in the active area.
REQ-012 oVgaRequest  out  1  oVgaHRequest AND oVgaVRequest.
REQ-013 oHSync, oVSync  out  1 each  sync pulses, active-low.
REQ-014 oPixelAddress  out  20  {row[9:0], col[9:0]} of the current position.
REQ-015 oHIndex, oVIndex  out  16 each  current column and row, zero-extended.
REQ-016 oFrameStart  out  1  one-cycle pulse at pixel (0,0).
REQ-017 oFreezeActive  out  1  frame-aligned freeze state.
REQ-018 oWriteEnable  out  1  oVgaRequest AND NOT oFreezeActive.
REQ-019 oFrameCount  out  16  completed-frame counter.

Function
REQ-020 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
REQ-021 Internal column counter h runs 0..H_TOTAL-1 and advances every clock; it wraps from H_TOTAL-1 to 0.
REQ-022 Internal row counter v advances only on an h wrap; it runs 0..V_TOTAL-1 and wraps from V_TOTAL-1 to 0.
REQ-023 All outputs are registered and describe the (h,v) loaded on the same edge; there is no combinational path from counters to ports.
REQ-024 oVgaHRequest = (h < H_ACTIVE); oVgaVRequest = (v < V_ACTIVE).
REQ-025 oHSync is low for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (656..751).
REQ-026 oVSync is low for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (490..491) across full lines.
REQ-027 oPixelAddress, oHIndex, and oVIndex track h and v at all times, including the blanking intervals.
REQ-028 oFrameStart is 1 exactly in cycles where h=0 and v=0.
REQ-029 oFreezeActive samples iFreezeReq only on the edge that loads (0,0); it holds otherwise, so a freeze never splits a frame.
REQ-030 oFrameCount increments on each edge loading (0,0), except the first after reset; it wraps at 0xFFFF to 0.
REQ-031 An iFreezeReq toggle that does not persist to a frame-start edge has no effect.

Reset
REQ-032 When reset_n=0 at an edge, internal h=H_TOTAL-1 and v=V_TOTAL-1.
REQ-033 When reset_n=0 at an edge, the following outputs are set: oVgaHRequest, oVgaVRequest, oVgaRequest, oWriteEnable, and oFrameStart are 0; oHSync and oVSync are 1; oPixelAddress, oHIndex, oVIndex, and oFrameCount are 0; oFreezeActive is 0.
REQ-034 On the first edge with reset_n=1, the block loads (0,0): oFrameStart=1, oVgaRequest=1, and oFreezeActive=iFreezeReq.
REQ-035 Reset asserted mid-frame takes effect on the next edge regardless of position; no partial state survives.

Verification
REQ-036 Scenario: release reset, iFreezeReq=0 -> first active cycle has oPixelAddress=0x00000, oVgaRequest=1, oFrameStart=1, and oWriteEnable=1.
REQ-037 Scenario: run 1 line -> oVgaHRequest high for 640 cycles, oHSync low for 96 cycles starting at h=656, and the line repeats every 800 cycles.
REQ-038 Scenario: run 2 frames -> oFrameStart pulses spaced 420000 cycles apart, oVSync low for 1600 cycles, oFrameCount=1 after the second pulse, and the last active address is {10'd479,10'd639}=0x77E7F.
REQ-039 Scenario: iFreezeReq raised at (100,200) -> oFreezeActive stays 0 and oWriteEnable keeps following oVgaRequest until the next (0,0) edge; then oFreezeActive=1 and oWriteEnable=0 for the whole frame.
REQ-040 Scenario: iFreezeReq pulsed for 10 cycles mid-frame -> oFreezeActive never changes.
REQ-041 Scenario: reset_n pulled low at (300,300) for 1 cycle -> outputs take the REQ-033 values, the next edge loads (0,0) with oFrameStart=1, and oFrameCount=0.

Source files
------------

// File: rtl/vga_request_gen.sv
// VGA raster timing generator: free-running column/row counters with registered
// request, sync, address and frame-aligned freeze outputs for a pixel-RAM writer.
module vga_request_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        iVgaClk,
  input  logic        reset_n,
  input  logic        iFreezeReq,
  output logic        oVgaHRequest,
  output logic        oVgaVRequest,
  output logic        oVgaRequest,
  output logic        oHSync,
  output logic        oVSync,
  output logic [19:0] oPixelAddress,
  output logic [15:0] oHIndex,
  output logic [15:0] oVIndex,
  output logic        oFrameStart,
  output logic        oFreezeActive,
  output logic        oWriteEnable,
  output logic [15:0] oFrameCount
);

  localparam logic [15:0] L_HA  = 16'(H_ACTIVE);
  localparam logic [15:0] L_HS0 = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] L_HS1 = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] L_HT  = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [15:0] L_VA  = 16'(V_ACTIVE);
  localparam logic [15:0] L_VS0 = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] L_VS1 = 16'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [15:0] L_VT  = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP);

  logic [15:0] r_h, r_v;
  logic        r_first;
  logic [15:0] w_h_nxt, w_v_nxt;
  logic        w_h_wrap, w_origin, w_hreq, w_vreq, w_frz_nxt;

  // Outputs are computed from the position being loaded, so ports describe (r_h,r_v)
  always_comb begin
    w_h_wrap  = (r_h == L_HT - 16'd1);
    w_h_nxt   = w_h_wrap ? 16'd0 : r_h + 16'd1;
    w_v_nxt   = r_v;
    if (w_h_wrap) w_v_nxt = (r_v == L_VT - 16'd1) ? 16'd0 : r_v + 16'd1;
    w_origin  = (w_h_nxt == 16'd0) && (w_v_nxt == 16'd0);
    w_hreq    = (w_h_nxt < L_HA);
    w_vreq    = (w_v_nxt < L_VA);
    w_frz_nxt = w_origin ? iFreezeReq : oFreezeActive;
  end

  always_ff @(posedge iVgaClk) begin
    if (!reset_n) begin
      r_h           <= L_HT - 16'd1;
      r_v           <= L_VT - 16'd1;
      r_first       <= 1'b1;
      oVgaHRequest  <= 1'b0;
      oVgaVRequest  <= 1'b0;
      oVgaRequest   <= 1'b0;
      oHSync        <= 1'b1;
      oVSync        <= 1'b1;
      oPixelAddress <= 20'd0;
      oHIndex       <= 16'd0;
      oVIndex       <= 16'd0;
      oFrameStart   <= 1'b0;
      oFreezeActive <= 1'b0;
      oWriteEnable  <= 1'b0;
      oFrameCount   <= 16'd0;
    end else begin
      r_h           <= w_h_nxt;
      r_v           <= w_v_nxt;
      oVgaHRequest  <= w_hreq;
      oVgaVRequest  <= w_vreq;
      oVgaRequest   <= w_hreq & w_vreq;
      oHSync        <= !((w_h_nxt >= L_HS0) && (w_h_nxt < L_HS1));
      oVSync        <= !((w_v_nxt >= L_VS0) && (w_v_nxt < L_VS1));
      oPixelAddress <= {w_v_nxt[9:0], w_h_nxt[9:0]};
      oHIndex       <= w_h_nxt;
      oVIndex       <= w_v_nxt;
      oFrameStart   <= w_origin;
      oFreezeActive <= w_frz_nxt;
      oWriteEnable  <= w_hreq & w_vreq & ~w_frz_nxt;
      // The frame that starts right out of reset is not a completed frame
      if (w_origin) begin
        if (r_first) r_first <= 1'b0;
        else         oFrameCount <= oFrameCount + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_request_gen.sv
// Randomized scoreboard bench for vga_request_gen on a reduced raster.
module tb_vga_request_gen;
  localparam int HA = 16, HFP = 2, HSY = 3, HBP = 4;
  localparam int VA = 8,  VFP = 2, VSY = 2, VBP = 3;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;

  typedef struct packed {
    logic        hreq, vreq, req, hs, vs;
    logic [19:0] addr;
    logic [15:0] hi, vi;
    logic        fs, frz, we;
    logic [15:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic freeze_req = 1'b0;
  logic hreq, vreq, req, hs, vs, fs, frz, we;
  logic [19:0] addr;
  logic [15:0] hi, vi, fc;

  int checks = 0;
  int errors = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  vga_request_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
  ) dut (
    .iVgaClk(clk), .reset_n(reset_n), .iFreezeReq(freeze_req),
    .oVgaHRequest(hreq), .oVgaVRequest(vreq), .oVgaRequest(req),
    .oHSync(hs), .oVSync(vs), .oPixelAddress(addr),
    .oHIndex(hi), .oVIndex(vi), .oFrameStart(fs),
    .oFreezeActive(frz), .oWriteEnable(we), .oFrameCount(fc)
  );

  // Reference: position is simply the number of clean cycles since reset, mod raster size
  initial begin
    int n, h, v;
    bit first;
    bit m_frz;
    int m_fc;
    exp_t e;
    n = 0; first = 1'b1; m_frz = 1'b0; m_fc = 0;
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        e = '0;
        e.hs = 1'b1; e.vs = 1'b1;
        n = 0; first = 1'b1; m_frz = 1'b0; m_fc = 0;
      end else begin
        h = n % HT;
        v = (n / HT) % VT;
        if (h == 0 && v == 0) begin
          if (first) first = 1'b0;
          else m_fc = (m_fc + 1) % 65536;
          m_frz = freeze_req;
        end
        e.hreq = (h < HA);
        e.vreq = (v < VA);
        e.req  = e.hreq && e.vreq;
        e.hs   = !(h >= HA + HFP && h < HA + HFP + HSY);
        e.vs   = !(v >= VA + VFP && v < VA + VFP + VSY);
        e.addr = {10'(v), 10'(h)};
        e.hi   = 16'(h);
        e.vi   = 16'(v);
        e.fs   = (h == 0 && v == 0);
        e.frz  = m_frz;
        e.we   = e.req && !m_frz;
        e.fc   = 16'(m_fc);
        n++;
      end
      q.push_back(e);
    end
  end

  // Monitor: pops one expectation per presented output cycle; also checks frame spacing
  initial begin
    exp_t e, a;
    int cyc, last_fs;
    cyc = 0; last_fs = -1;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) last_fs = -1;
      if (q.size() > 0) begin
        e = q.pop_front();
        a = '{hreq, vreq, req, hs, vs, addr, hi, vi, fs, frz, we, fc};
        checks++;
        if (a !== e) begin
          errors++;
          if (errors <= 20)
            $display("FAIL outputs cyc=%0d got=%h exp=%h (addr %h/%h fc %h/%h frz %b/%b we %b/%b)",
                     cyc, a, e, a.addr, e.addr, a.fc, e.fc, a.frz, e.frz, a.we, e.we);
        end
        if (fs === 1'b1 && reset_n) begin
          if (last_fs >= 0) begin
            checks++;
            if (cyc - last_fs != HT * VT) begin
              errors++;
              if (errors <= 20)
                $display("FAIL frame_spacing got=%0d exp=%0d", cyc - last_fs, HT * VT);
            end
          end
          last_fs = cyc;
        end
      end
    end
  end

  task automatic run(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    run(2);
    reset_n = 1'b1;                         // release, freeze low
    run(2 * HT * VT + 5);
    run(HT * VT / 2);
    freeze_req = 1'b1;                      // raised mid-frame, held past a frame start
    run(HT * VT + HT * 3);
    freeze_req = 1'b0;
    run(HT * VT);
    run(HT * 4 + 7);
    freeze_req = 1'b1;                      // short pulse, must not reach a frame start
    run(10);
    freeze_req = 1'b0;
    run(HT * VT);
    run(HT * 5 + 9);
    reset_n = 1'b0;                         // one-cycle reset mid-frame
    run(1);
    reset_n = 1'b1;
    run(2 * HT * VT);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 49) == 0) freeze_req = ~freeze_req;
      reset_n = ($urandom_range(0, 1499) != 0);
      run(1);
    end
    reset_n = 1'b1;
    run(HT * VT + 3);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
